// File: rtl/sd_pkg.sv
// Shared SD-card definitions: DAT receiver state encoding, CRC polynomials and step functions,
// default block geometry. The command controller uses crc7_step from here.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_DATA,
        ST_CRC,
        ST_ENDBIT
    } sddat_state_e;

    localparam logic [15:0] CRC16_POLY      = 16'h1021;
    localparam logic [6:0]  CRC7_POLY       = 7'h09;
    localparam int          DEF_BLOCK_BYTES = 512;
    localparam logic [15:0] DEF_START_TMO   = 16'hFFFF;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (init 0). clr has priority over en.
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)
            crc_d = 16'h0000;
        else if (en)
            crc_d = crc16_step(crc_q, din);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) crc_q <= 16'h0000;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sddat_rd_block.sv
// Single-block SD DAT0 receiver (1-bit mode) for CMD17 reads.
// Define SDDAT_CRC_CHECK_EN to check the received CRC16; otherwise only the end bit is checked.
module sddat_rd_block
    import sd_pkg::*;
#(
    parameter int          BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter logic [15:0] START_TMO   = DEF_START_TMO
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sdclk,
    input  logic       sddat0,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       crcerr,
    output logic       outen,
    output logic [8:0] outaddr,
    output logic [7:0] outbyte
);

    localparam logic [8:0] LAST_BYTE = 9'(BLOCK_BYTES - 1);

    sddat_state_e state_q, state_d;
    logic        sdclk_q, rise, arm, crc_mismatch;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  byte_q, byte_d;
    logic [6:0]  shift_q, shift_d;
    logic        done_q, done_d, timeout_q, timeout_d, crcerr_q, crcerr_d, outen_q, outen_d;
    logic [8:0]  outaddr_q, outaddr_d;
    logic [7:0]  outbyte_q, outbyte_d;

    assign rise = sdclk & ~sdclk_q;
    assign arm  = (state_q == ST_IDLE) && start && !abort;

`ifdef SDDAT_CRC_CHECK_EN
    logic [15:0] crc_calc, crc_rx_q, crc_rx_d;

    sd_crc16 u_crc16 (
        .clk  (clk),
        .rstn (rstn),
        .clr  (arm),
        .en   (rise && (state_q == ST_DATA)),
        .din  (sddat0),
        .crc  (crc_calc)
    );

    always_comb begin
        crc_rx_d = crc_rx_q;
        if (rise && (state_q == ST_CRC))
            crc_rx_d = {crc_rx_q[14:0], sddat0};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) crc_rx_q <= 16'h0000;
        else       crc_rx_q <= crc_rx_d;
    end

    assign crc_mismatch = (crc_rx_q != crc_calc);
`else
    assign crc_mismatch = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        outaddr_d = outaddr_q;
        outbyte_d = outbyte_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        crcerr_d  = 1'b0;
        outen_d   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d = ST_WAIT_START;
                    tmo_d   = START_TMO;
                    cnt_d   = 4'd0;
                    byte_d  = 9'd0;
                end
                ST_WAIT_START: if (rise) begin
                    if (!sddat0) begin
                        state_d = ST_DATA;
                    end else if (tmo_q == 16'd1) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q - 16'd1;
                    end
                end
                ST_DATA: if (rise) begin
                    shift_d = {shift_q[5:0], sddat0};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d     = 4'd0;
                        outen_d   = 1'b1;
                        outbyte_d = {shift_q, sddat0};
                        outaddr_d = byte_q;
                        if (byte_q == LAST_BYTE) state_d = ST_CRC;
                        else                     byte_d  = byte_q + 9'd1;
                    end
                end
                // cnt wraps 15 -> 0 on the last CRC bit
                ST_CRC: if (rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = ST_ENDBIT;
                end
                ST_ENDBIT: if (rise) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    crcerr_d = !sddat0 || crc_mismatch;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            sdclk_q   <= 1'b0;
            tmo_q     <= 16'h0000;
            cnt_q     <= 4'd0;
            byte_q    <= 9'd0;
            shift_q   <= 7'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crcerr_q  <= 1'b0;
            outen_q   <= 1'b0;
            outaddr_q <= 9'd0;
            outbyte_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            sdclk_q   <= sdclk;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            crcerr_q  <= crcerr_d;
            outen_q   <= outen_d;
            outaddr_q <= outaddr_d;
            outbyte_q <= outbyte_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign timeout = timeout_q;
    assign crcerr  = crcerr_q;
    assign outen   = outen_q;
    assign outaddr = outaddr_q;
    assign outbyte = outbyte_q;

endmodule

// File: tb/tb_sddat_rd_block.sv
// Bench for sddat_rd_block: table of block scenarios plus hand sequences for timeout, abort and reset.
// Expected bytes and CRC come from the bench's own block buffer and a polynomial-division CRC.
module tb_sddat_rd_block;

    localparam int NB = 512;
`ifdef SDDAT_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       clk = 1'b0, rstn = 1'b0, sdclk = 1'b1, sddat0 = 1'b1, start = 1'b0, abort = 1'b0;
    logic       busy, done, timeout, crcerr, outen;
    logic [8:0] outaddr;
    logic [7:0] outbyte;

    sddat_rd_block #(.BLOCK_BYTES(NB), .START_TMO(16'd16)) dut (
        .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat0(sddat0), .start(start), .abort(abort),
        .busy(busy), .done(done), .timeout(timeout), .crcerr(crcerr), .outen(outen),
        .outaddr(outaddr), .outbyte(outbyte)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] blk [NB];
    logic [8:0] mon_addr [$];
    logic [7:0] mon_byte [$];
    int n_done = 0, n_stray = 0;

    always @(negedge clk) if (rstn) begin
        if (outen) begin
            mon_addr.push_back(outaddr);
            mon_byte.push_back(outbyte);
        end
        if (done) n_done++;
        if ((!done && (timeout || crcerr)) || (done && busy)) n_stray++;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_ref();
        logic [16:0] r;
        r = '0;
        for (int i = 0; i < NB*8 + 16; i++) begin
            logic bitv;
            bitv = (i < NB*8) ? blk[i/8][7 - (i%8)] : 1'b0;
            r = {r[15:0], bitv};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic fill(input bit rnd);
        for (int i = 0; i < NB; i++) blk[i] = rnd ? 8'($urandom) : 8'(i);
    endtask

    task automatic sd_edge(input logic b);
        sddat0 = b;
        sdclk  = 1'b0;
        @(posedge clk); #1 sdclk = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 7; k >= 0; k--) sd_edge(v[k]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic chk_stream(input string nm, input int n);
        int bad;
        bad = -1;
        chk({nm, " outen count"}, mon_addr.size(), n);
        for (int i = 0; i < mon_addr.size() && i < n; i++)
            if (bad < 0 && (mon_addr[i] !== 9'(i) || mon_byte[i] !== blk[i])) bad = i;
        chk({nm, " first bad byte index"}, bad, -1);
    endtask

    task automatic run_block(input string nm, input int idle, input bit flip, input bit endb,
                             input bit mid, input bit exp_crcerr);
        logic [15:0] c;
        int d0;
        c = crc_ref() ^ {15'd0, flip};
        mon_addr.delete();
        mon_byte.delete();
        d0 = n_done;
        pulse_start();
        chk({nm, " busy after start"}, busy, 1);
        repeat (idle) sd_edge(1'b1);
        sd_edge(1'b0);
        for (int i = 0; i < NB; i++) begin
            if (mid && i == 200) pulse_start();
            send_byte(blk[i]);
        end
        chk({nm, " busy before crc"}, busy, 1);
        for (int k = 15; k >= 0; k--) sd_edge(c[k]);
        sd_edge(endb);
        chk({nm, " done"}, done, 1);
        chk({nm, " timeout"}, timeout, 0);
        chk({nm, " crcerr"}, crcerr, exp_crcerr);
        chk({nm, " busy at done"}, busy, 0);
        @(posedge clk); #1;
        chk({nm, " done pulse width"}, done, 0);
        chk_stream(nm, NB);
        chk({nm, " done count"}, n_done - d0, 1);
    endtask

    typedef struct {
        int idle;
        bit rnd;
        bit flip;
        bit endb;
        bit mid;
        bit exp_crcerr;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int d0;

        tbl[0] = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};               // good block, 0x00..0xFF twice
        tbl[1] = '{0, 1'b1, 1'b1, 1'b1, 1'b0, CRC_EN};             // flipped CRC bit 0
        tbl[2] = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};              // end bit 0, start bit on last allowed edge
        tbl[3] = '{int'($urandom_range(0, 14)), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};               // start pulsed mid-data

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset timeout", timeout, 0);
        chk("reset crcerr", crcerr, 0);
        chk("reset outen", outen, 0);
        chk("reset outaddr", outaddr, 0);
        chk("reset outbyte", outbyte, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            fill(tbl[i].rnd);
            run_block($sformatf("vec%0d", i), tbl[i].idle, tbl[i].flip, tbl[i].endb,
                      tbl[i].mid, tbl[i].exp_crcerr);
        end

        // no start bit: done+timeout right after the 16th edge
        mon_addr.delete();
        mon_byte.delete();
        pulse_start();
        repeat (15) sd_edge(1'b1);
        chk("tmo done before edge 16", done, 0);
        chk("tmo busy before edge 16", busy, 1);
        sd_edge(1'b1);
        chk("tmo done", done, 1);
        chk("tmo timeout", timeout, 1);
        chk("tmo crcerr", crcerr, 0);
        chk("tmo busy", busy, 0);
        @(posedge clk); #1;
        chk("tmo timeout pulse width", timeout, 0);
        chk("tmo outen count", mon_addr.size(), 0);

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", busy, 0);

        // abort after byte 100
        fill(1'b1);
        mon_addr.delete();
        mon_byte.delete();
        d0 = n_done;
        pulse_start();
        sd_edge(1'b1);
        sd_edge(1'b0);
        for (int i = 0; i <= 100; i++) send_byte(blk[i]);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort busy", busy, 0);
        for (int k = 0; k < 40; k++) sd_edge(1'($urandom_range(0, 1)));
        chk_stream("abort", 101);
        chk("abort done count", n_done - d0, 0);
        fill(1'b1);
        run_block("after abort", 2, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset in the middle of DATA
        fill(1'b1);
        pulse_start();
        sd_edge(1'b0);
        for (int i = 0; i < 50; i++) send_byte(blk[i]);
        rstn = 1'b0;
        #3;
        chk("midrst busy", busy, 0);
        chk("midrst outen", outen, 0);
        chk("midrst outaddr", outaddr, 0);
        chk("midrst outbyte", outbyte, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        chk("after rst busy", busy, 0);
        chk("after rst done", done, 0);
        fill(1'b1);
        run_block("after reset", 4, 1'b0, 1'b1, 1'b0, 1'b0);

        chk("stray timeout/crcerr/done-busy", n_stray, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
